// File: rtl/relobi_rr_arb_ctrl.sv
// relobi_rr_arb_ctrl: TMR round-robin arbiter and in-order response router for a reliable OBI N-to-1 mux
//   clk_i, rst_i                : clock, synchronous active-high reset
//   sbr_req_i / sbr_gnt_o       : per-replica, per-port request/grant
//   sbr_rvalid_o / sbr_rready_i : per-replica, per-port response handshake
//   mgr_req_o / mgr_gnt_i       : per-replica request/grant on the shared port
//   mgr_rvalid_i / mgr_rready_o : per-replica response handshake on the shared port
//   req_sel_o / rsp_sel_o       : per-replica a-channel and r-channel select indices
//   fault_o                     : [0] replica disagreement, [1] response with nothing outstanding
//   RELOBI_ARB_STICKY_FAULT_EN  : when defined, fault_o bits hold until rst_i
module relobi_rr_arb_ctrl #(
  parameter int unsigned NumSbrPorts = 4,
  parameter int unsigned NumMaxTrans = 4,
  parameter int unsigned IdxWidth    = $clog2(NumSbrPorts),
  parameter int unsigned CntWidth    = $clog2(NumMaxTrans + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [2:0][NumSbrPorts-1:0] sbr_req_i,
  output logic [2:0][NumSbrPorts-1:0] sbr_gnt_o,
  output logic [2:0][NumSbrPorts-1:0] sbr_rvalid_o,
  input  logic [2:0][NumSbrPorts-1:0] sbr_rready_i,
  output logic [2:0]                  mgr_req_o,
  input  logic [2:0]                  mgr_gnt_i,
  input  logic [2:0]                  mgr_rvalid_i,
  output logic [2:0]                  mgr_rready_o,
  output logic [2:0][IdxWidth-1:0]    req_sel_o,
  output logic [2:0][IdxWidth-1:0]    rsp_sel_o,
  output logic [1:0]                  fault_o
);
  localparam int unsigned PtrWidth = NumMaxTrans > 1 ? $clog2(NumMaxTrans) : 1;
  typedef struct packed {
    logic [IdxWidth-1:0]                  rr;
    logic                                 lock;
    logic [IdxWidth-1:0]                  lidx;
    logic [NumMaxTrans-1:0][IdxWidth-1:0] fifo;
    logic [PtrWidth-1:0]                  wr;
    logic [PtrWidth-1:0]                  rd;
  } core_t;
  core_t [2:0]               core_all;
  logic  [2:0][CntWidth-1:0] cnt_all;
  core_t                     q;
  logic  [CntWidth-1:0]      cnt;
  logic  [2:0]               perr;
  logic  [1:0]               flt;
  // every replica advances from the same voted state, so a single upset is scrubbed next cycle
  assign q   = (core_all[0] & core_all[1]) | (core_all[0] & core_all[2]) | (core_all[1] & core_all[2]);
  assign cnt = (cnt_all[0] & cnt_all[1]) | (cnt_all[0] & cnt_all[2]) | (cnt_all[1] & cnt_all[2]);
  for (genvar r = 0; r < 3; r++) begin : g_rep
    core_t                  st_q, st_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [NumSbrPorts-1:0] req, gnt, rvalid;
    logic [IdxWidth-1:0]    cand, rsp, k;
    logic                   found, mreq, hs, nonempty, rready, pop;
    assign req = sbr_req_i[r];
    always_comb begin
      found = 1'b0;
      cand  = q.rr;
      k     = '0;
      for (int i = 0; i < NumSbrPorts; i++) begin
        k = IdxWidth'((int'(q.rr) + i) % NumSbrPorts);
        if (!found && req[k]) begin
          found = 1'b1;
          cand  = k;
        end
      end
      if (q.lock) cand = q.lidx;
    end
    assign mreq     = (q.lock | (|req)) & (cnt < CntWidth'(NumMaxTrans));
    assign hs       = mreq & mgr_gnt_i[r];
    assign rsp      = q.fifo[q.rd];
    assign nonempty = cnt != '0;
    assign rready   = nonempty ? sbr_rready_i[r][rsp] : 1'b1;
    assign pop      = mgr_rvalid_i[r] & rready & nonempty;
    assign gnt      = hs ? NumSbrPorts'(1) << cand : '0;
    assign rvalid   = (nonempty & mgr_rvalid_i[r]) ? NumSbrPorts'(1) << rsp : '0;
    // an ungranted request locks its port so the a channel stays stable until accepted
    always_comb begin
      st_d = q;
      if (hs) begin
        st_d.fifo[q.wr] = cand;
        st_d.wr         = (q.wr == PtrWidth'(NumMaxTrans - 1)) ? '0 : q.wr + PtrWidth'(1);
        st_d.rr         = (cand == IdxWidth'(NumSbrPorts - 1)) ? '0 : cand + IdxWidth'(1);
        st_d.lock       = 1'b0;
      end else if (mreq) begin
        st_d.lock = 1'b1;
        st_d.lidx = cand;
      end
      if (pop) st_d.rd = (q.rd == PtrWidth'(NumMaxTrans - 1)) ? '0 : q.rd + PtrWidth'(1);
      cnt_d = cnt + CntWidth'(hs) - CntWidth'(pop);
    end
    always_ff @(posedge clk_i) begin
      st_q  <= rst_i ? '0 : st_d;
      cnt_q <= rst_i ? '0 : cnt_d;
    end
    assign core_all[r]     = st_q;
    assign cnt_all[r]      = cnt_q;
    assign perr[r]         = mgr_rvalid_i[r] & ~nonempty;
    assign sbr_gnt_o[r]    = gnt;
    assign sbr_rvalid_o[r] = rvalid;
    assign mgr_req_o[r]    = mreq;
    assign mgr_rready_o[r] = rready;
    assign req_sel_o[r]    = cand;
    assign rsp_sel_o[r]    = rsp;
  end
  assign flt = {|perr, (core_all[0] != core_all[1]) | (core_all[1] != core_all[2]) |
                       (cnt_all[0] != cnt_all[1]) | (cnt_all[1] != cnt_all[2])};
`ifdef RELOBI_ARB_STICKY_FAULT_EN
  logic [1:0] flt_q;
  always_ff @(posedge clk_i) flt_q <= rst_i ? '0 : flt_q | flt;
  assign fault_o = flt_q | flt;
`else
  assign fault_o = flt;
`endif
endmodule

// File: tb/tb_relobi_rr_arb_ctrl.sv
// tb_relobi_rr_arb_ctrl: directed vector bench for relobi_rr_arb_ctrl (4 ports, 4 outstanding)
module tb_relobi_rr_arb_ctrl;
`ifdef RELOBI_ARB_STICKY_FAULT_EN
  localparam bit Stk = 1'b1;
`else
  localparam bit Stk = 1'b0;
`endif
  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [2:0][3:0] sbr_req_i, sbr_gnt_o, sbr_rvalid_o, sbr_rready_i;
  logic [2:0]      mgr_req_o, mgr_gnt_i, mgr_rvalid_i, mgr_rready_o;
  logic [2:0][1:0] req_sel_o, rsp_sel_o;
  logic [1:0]      fault_o;
  int              tests = 0;
  int              fails = 0;
  typedef struct {
    logic [3:0] req;
    logic       gnt, rv;
    logic [3:0] rdy;
    logic       mreq;
    logic [1:0] rsel;
    logic [3:0] g, rvo;
    logic [1:0] ssel;
    logic       mrr;
    logic [1:0] flt;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  relobi_rr_arb_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .sbr_req_i(sbr_req_i), .sbr_gnt_o(sbr_gnt_o),
    .sbr_rvalid_o(sbr_rvalid_o), .sbr_rready_i(sbr_rready_i),
    .mgr_req_o(mgr_req_o), .mgr_gnt_i(mgr_gnt_i),
    .mgr_rvalid_i(mgr_rvalid_i), .mgr_rready_o(mgr_rready_o),
    .req_sel_o(req_sel_o), .rsp_sel_o(rsp_sel_o), .fault_o(fault_o)
  );
  function automatic vec_t mk(input logic [3:0] req, input logic gnt, rv, input logic [3:0] rdy,
                              input logic mreq, input logic [1:0] rsel, input logic [3:0] g, rvo,
                              input logic [1:0] ssel, input logic mrr, input logic [1:0] flt);
    vec_t x;
    x.req = req; x.gnt = gnt; x.rv = rv; x.rdy = rdy; x.mreq = mreq; x.rsel = rsel;
    x.g = g; x.rvo = rvo; x.ssel = ssel; x.mrr = mrr; x.flt = flt;
    return x;
  endfunction
  function automatic logic [13:0] obs(input int r);
    return {mgr_req_o[r], req_sel_o[r], sbr_gnt_o[r], sbr_rvalid_o[r], rsp_sel_o[r], mgr_rready_o[r]};
  endfunction
  task automatic drive(input logic [3:0] req, input logic g, rv, input logic [3:0] rdy);
    sbr_req_i = {3{req}};
    mgr_gnt_i = {3{g}};
    mgr_rvalid_i = {3{rv}};
    sbr_rready_i = {3{rdy}};
  endtask
  task automatic chk(input string nm, input logic [63:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    logic [13:0] e;
    // reset state, then ports 1/3 alternating with responses one cycle behind
    v.push_back(mk(4'b0000, 0, 0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b1010, 1, 0, 4'b1111, 1, 1, 4'b0010, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b1010, 1, 1, 4'b1111, 1, 3, 4'b1000, 4'b0010, 1, 1, 2'b00));
    v.push_back(mk(4'b1010, 1, 1, 4'b1111, 1, 1, 4'b0010, 4'b1000, 3, 1, 2'b00));
    v.push_back(mk(4'b1010, 1, 1, 4'b1111, 1, 3, 4'b1000, 4'b0010, 1, 1, 2'b00));
    v.push_back(mk(4'b0000, 1, 1, 4'b1111, 0, 0, 4'b0000, 4'b1000, 3, 1, 2'b00));
    // port 2 locked through three stalled cycles while port 0 also requests
    v.push_back(mk(4'b0100, 0, 0, 4'b1111, 1, 2, 4'b0000, 4'b0000, 1, 1, 2'b00));
    v.push_back(mk(4'b0101, 0, 0, 4'b1111, 1, 2, 4'b0000, 4'b0000, 1, 1, 2'b00));
    v.push_back(mk(4'b0101, 0, 0, 4'b1111, 1, 2, 4'b0000, 4'b0000, 1, 1, 2'b00));
    v.push_back(mk(4'b0101, 1, 0, 4'b1111, 1, 2, 4'b0100, 4'b0000, 1, 1, 2'b00));
    v.push_back(mk(4'b1001, 1, 1, 4'b1111, 1, 3, 4'b1000, 4'b0100, 2, 1, 2'b00));
    v.push_back(mk(4'b0000, 0, 1, 4'b0000, 0, 0, 4'b0000, 4'b1000, 3, 0, 2'b00));
    v.push_back(mk(4'b0000, 0, 1, 4'b1000, 0, 0, 4'b0000, 4'b1000, 3, 1, 2'b00));
    // fill to four outstanding, then full behaviour
    v.push_back(mk(4'b0001, 1, 0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 1, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 1, 4'b1111, 0, 0, 4'b0000, 4'b0001, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 1, 4'b1111, 0, 0, 4'b0000, 4'b0001, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 1, 4'b1111, 1, 0, 4'b0001, 4'b0001, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 1, 0, 4'b1111, 1, 0, 4'b0001, 4'b0000, 0, 1, 2'b00));
    v.push_back(mk(4'b0001, 0, 0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 1, 2'b00));
    for (int i = 0; i < 4; i++)
      v.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 1, 4'b0000, 4'b0001, 0, 1, 2'b00));
    // response with nothing outstanding
    v.push_back(mk(4'b0000, 0, 1, 4'b1111, 0, 1, 4'b0000, 4'b0000, 0, 1, 2'b10));
    v.push_back(mk(4'b0000, 0, 0, 4'b1111, 0, 1, 4'b0000, 4'b0000, 0, 1, Stk ? 2'b10 : 2'b00));
    drive(4'b0000, 0, 0, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_i = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      drive(v[i].req, v[i].gnt, v[i].rv, v[i].rdy);
      #1;
      e = {v[i].mreq, v[i].rsel, v[i].g, v[i].rvo, v[i].ssel, v[i].mrr};
      chk($sformatf("vec%0d", i), {obs(0), obs(1), obs(2), fault_o}, {e, e, e, v[i].flt});
    end
    // upset one replica's count: flagged for one cycle, voted value keeps behaviour intact
    @(negedge clk);
    drive(4'b0000, 0, 0, 4'b0000);
    force dut.g_rep[1].cnt_q = 3'd1;
    #1;
    chk("upset_flag", fault_o[0], 1'b1);
    chk("upset_masked", mgr_rready_o, 3'b111);
    release dut.g_rep[1].cnt_q;
    @(negedge clk);
    drive(4'b0001, 1, 0, 4'b1111);
    #1;
    chk("upset_cleared", fault_o, Stk ? 2'b11 : 2'b00);
    chk("upset_traffic", {sbr_gnt_o, mgr_req_o, req_sel_o}, {{3{4'b0001}}, 3'b111, 6'd0});
    // lock port 2, then reset with a transaction outstanding
    @(negedge clk);
    drive(4'b0100, 0, 0, 4'b1111);
    #1;
    chk("prelock", req_sel_o, {3{2'd2}});
    @(negedge clk);
    rst_i = 1'b1;
    drive(4'b0000, 0, 0, 4'b1111);
    @(negedge clk);
    rst_i = 1'b0;
    drive(4'b0001, 0, 1, 4'b1111);
    #1;
    chk("rst_lock", req_sel_o, 6'd0);
    chk("rst_rsp", {sbr_rvalid_o, mgr_rready_o, rsp_sel_o}, {12'd0, 3'b111, 6'd0});
    chk("rst_perr", fault_o, 2'b10);
    @(negedge clk);
    drive(4'b0000, 0, 0, 4'b1111);
    #1;
    chk("perr_after", fault_o, Stk ? 2'b10 : 2'b00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
